// File: rtl/fc_loss_grad_argmax.sv
// -----------------------------------------------------------------------------
// fc_loss_grad_argmax
//
// Output-layer loss/gradient stage placed after the fully connected forward
// layer. On start it latches the NUM_CLASSES logits and the true label, then
// walks the classes one per cycle. For each class it produces the gradient
// ((logit - target) >>> SHIFT, saturated to GRAD_W bits) for the backward
// layer, accumulates the absolute gradient, and tracks the running argmax.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   start       in   begin a pass (sampled only in IDLE)
//   logits      in   NUM_CLASSES*IN_W flattened signed logits, class k at [k*IN_W +: IN_W]
//   label       in   true class index
//   grad_out    out  NUM_CLASSES*GRAD_W flattened signed gradients
//   pred_class  out  index of the largest logit (ties keep the lower index)
//   correct     out  pred_class == label with a valid label
//   abs_err     out  saturating sum of |grad_k|
//   label_err   out  latched label was out of range
//   busy        out  high from LOAD through FINISH
//   done        out  one-cycle pulse when every output is valid
// -----------------------------------------------------------------------------
module fc_loss_grad_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IN_W        = 32,
    parameter int GRAD_W      = 16,
    parameter int SHIFT       = 8,
    parameter int ONE         = 256,
    parameter int LBL_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CLASSES*IN_W-1:0]   logits,
    input  logic [LBL_W-1:0]              label,
    output logic [NUM_CLASSES*GRAD_W-1:0] grad_out,
    output logic [LBL_W-1:0]              pred_class,
    output logic                          correct,
    output logic [31:0]                   abs_err,
    output logic                          label_err,
    output logic                          busy,
    output logic                          done
);

    localparam int ABS_W = 32;
    localparam logic [LBL_W-1:0]     LAST_K     = LBL_W'(NUM_CLASSES - 1);
    localparam logic signed [IN_W:0] G_MAX      = (IN_W+1)'((2 ** (GRAD_W - 1)) - 1);
    localparam logic signed [IN_W:0] G_MIN      = (IN_W+1)'(-(2 ** (GRAD_W - 1)));
    localparam logic signed [IN_W:0] TARGET_ONE = (IN_W+1)'(ONE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        FINISH
    } state_t;

    state_t                    state_q, state_d;
    logic [LBL_W-1:0]          k_q, k_d;
    logic signed [IN_W-1:0]    logit_q [NUM_CLASSES];
    logic signed [IN_W-1:0]    logit_d [NUM_CLASSES];
    logic signed [GRAD_W-1:0]  grad_q  [NUM_CLASSES];
    logic signed [GRAD_W-1:0]  grad_d  [NUM_CLASSES];
    logic [LBL_W-1:0]          label_q, label_d;
    logic                      label_err_q, label_err_d;
    logic [LBL_W-1:0]          best_idx_q, best_idx_d;
    logic signed [IN_W-1:0]    best_val_q, best_val_d;
    logic [ABS_W-1:0]          abs_err_q, abs_err_d;
    logic [LBL_W-1:0]          pred_class_q, pred_class_d;
    logic                      correct_q, correct_d;
    logic                      done_q, done_d;

    // Per-class datapath for the class currently selected by k_q.
    logic signed [IN_W-1:0]    cur_logit;
    logic                      cur_is_true;
    logic signed [IN_W:0]      cur_target;
    logic signed [IN_W:0]      cur_diff;
    logic signed [IN_W:0]      cur_shift;
    logic signed [GRAD_W-1:0]  cur_grad;
    logic [GRAD_W:0]           grad_ext;
    logic [GRAD_W:0]           cur_mag;
    logic [ABS_W:0]            abs_sum;

    // The difference is formed one bit wider than the logit so that the most
    // negative logit minus ONE cannot wrap; the shift is arithmetic, so
    // negative values round toward minus infinity.
    always_comb begin
        cur_logit   = logit_q[k_q];
        cur_is_true = (k_q == label_q) && !label_err_q;
        cur_target  = cur_is_true ? TARGET_ONE : '0;
        cur_diff    = {cur_logit[IN_W-1], cur_logit} - cur_target;
        cur_shift   = cur_diff >>> SHIFT;
        if (cur_shift > G_MAX) begin
            cur_grad = G_MAX[GRAD_W-1:0];
        end else if (cur_shift < G_MIN) begin
            cur_grad = G_MIN[GRAD_W-1:0];
        end else begin
            cur_grad = cur_shift[GRAD_W-1:0];
        end
        // One extra bit holds the magnitude of the most negative gradient.
        grad_ext = {cur_grad[GRAD_W-1], cur_grad};
        cur_mag  = cur_grad[GRAD_W-1] ? (~grad_ext + {{GRAD_W{1'b0}}, 1'b1}) : grad_ext;
        abs_sum  = {1'b0, abs_err_q} + {{(ABS_W - GRAD_W){1'b0}}, cur_mag};
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        logit_d      = logit_q;
        grad_d       = grad_q;
        label_d      = label_q;
        label_err_d  = label_err_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        abs_err_d    = abs_err_q;
        pred_class_d = pred_class_q;
        correct_d    = correct_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // The cycle carrying the done pulse never accepts a new start,
                // which leaves one quiet IDLE cycle between back-to-back passes.
                if (start && !done_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    logit_d[i] = logits[i*IN_W +: IN_W];
                end
                label_d     = label;
                label_err_d = (label > LAST_K);
                abs_err_d   = '0;
                correct_d   = 1'b0;
                k_d         = '0;
                best_idx_d  = '0;
                best_val_d  = logits[IN_W-1:0];
                state_d     = SCAN;
            end
            SCAN: begin
                grad_d[k_q] = cur_grad;
                abs_err_d   = abs_sum[ABS_W] ? {ABS_W{1'b1}} : abs_sum[ABS_W-1:0];
                // Strict compare: equal logits keep the earlier (lower) index.
                if (cur_logit > best_val_q) begin
                    best_idx_d = k_q;
                    best_val_d = cur_logit;
                end
                if (k_q == LAST_K) begin
                    state_d = FINISH;
                end else begin
                    k_d = k_q + LBL_W'(1);
                end
            end
            FINISH: begin
                pred_class_d = best_idx_q;
                correct_d    = (best_idx_q == label_q) && !label_err_q;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                logit_q[i] <= '0;
                grad_q[i]  <= '0;
            end
            label_q      <= '0;
            label_err_q  <= 1'b0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            abs_err_q    <= '0;
            pred_class_q <= '0;
            correct_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            logit_q      <= logit_d;
            grad_q       <= grad_d;
            label_q      <= label_d;
            label_err_q  <= label_err_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            abs_err_q    <= abs_err_d;
            pred_class_q <= pred_class_d;
            correct_q    <= correct_d;
            done_q       <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_grad_pack
        assign grad_out[g*GRAD_W +: GRAD_W] = grad_q[g];
    end

    assign pred_class = pred_class_q;
    assign correct    = correct_q;
    assign abs_err    = abs_err_q;
    assign label_err  = label_err_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_fc_loss_grad_argmax.sv
// -----------------------------------------------------------------------------
// tb_fc_loss_grad_argmax
//
// Self-checking bench for fc_loss_grad_argmax. A behavioural model computes
// the expected gradients, argmax, correct flag, absolute error and done cycle
// for every pass; a compare process checks the DUT on every done pulse.
// Directed passes additionally pin results against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_fc_loss_grad_argmax;

    localparam int NC = 10;

    typedef struct packed {
        logic [NC*16-1:0] grad;
        logic [3:0]       pred;
        logic             correct;
        logic [31:0]      abs_err;
        logic             lerr;
        int               done_cyc;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic [NC*32-1:0]   logits;
    logic [3:0]         label;
    logic [NC*16-1:0]   grad_out;
    logic [3:0]         pred_class;
    logic               correct;
    logic [31:0]        abs_err;
    logic               label_err;
    logic               busy;
    logic               done;

    int   total;
    int   bad;
    int   cyc;
    int   done_seen;
    bit   prev_done;
    exp_t exp_q[$];

    fc_loss_grad_argmax dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .logits     (logits),
        .label      (label),
        .grad_out   (grad_out),
        .pred_class (pred_class),
        .correct    (correct),
        .abs_err    (abs_err),
        .label_err  (label_err),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: floor division for the shift, clamp, plain argmax loop.
    function automatic exp_t model(input logic [NC*32-1:0] lg, input logic [3:0] lbl);
        exp_t   e;
        longint v;
        longint best;
        longint diff;
        longint g;
        longint sum;
        int     bi;
        bit     valid;
        e     = '0;
        valid = (int'(lbl) < NC);
        sum   = 0;
        bi    = 0;
        best  = longint'($signed(lg[31:0]));
        for (int k = 0; k < NC; k++) begin
            v    = longint'($signed(lg[k*32 +: 32]));
            diff = v - ((valid && k == int'(lbl)) ? 64'sd256 : 64'sd0);
            g    = diff / 256;
            if (diff < 0 && (diff % 256) != 0) g = g - 1;
            if (g > 32767) g = 32767;
            if (g < -32768) g = -32768;
            e.grad[k*16 +: 16] = g[15:0];
            sum = sum + ((g < 0) ? -g : g);
            if (v > best) begin
                best = v;
                bi   = k;
            end
        end
        if (sum > 64'sd4294967295) sum = 64'sd4294967295;
        e.pred    = bi[3:0];
        e.lerr    = !valid;
        e.correct = valid && (bi == int'(lbl));
        e.abs_err = sum[31:0];
        return e;
    endfunction

    // Compare process: every done pulse is matched against the oldest
    // expected pass, including the cycle on which it arrives.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                checkOutput("done_width", prev_done, 1'b0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_cycle", cyc, e.done_cyc);
                    for (int k = 0; k < NC; k++) begin
                        checkOutput($sformatf("grad_%0d", k), grad_out[k*16 +: 16],
                                    e.grad[k*16 +: 16]);
                    end
                    checkOutput("pred_class", pred_class, e.pred);
                    checkOutput("correct", correct, e.correct);
                    checkOutput("abs_err", abs_err, e.abs_err);
                    checkOutput("label_err", label_err, e.lerr);
                    checkOutput("busy_at_done", busy, 1'b0);
                end
                done_seen++;
            end
            prev_done = done;
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", (busy || done), 1'b0);
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", (done_seen >= target), 1'b1);
        if (done_seen < target) exp_q.delete();
    endtask

    // One pass: inputs are scrambled right after LOAD so results must come
    // from the latched copies; optionally pokes start while busy.
    task automatic applyStimulus(input logic [NC*32-1:0] lg, input logic [3:0] lbl,
                                 input bit poke_busy);
        exp_t e;
        int   target;
        waitIdle();
        logits = lg;
        label  = lbl;
        start  = 1'b1;
        e          = model(lg, lbl);
        e.done_cyc = cyc + 13;
        exp_q.push_back(e);
        target = done_seen + 1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NC; k++) logits[k*32 +: 32] = $urandom();
        label = 4'($urandom_range(0, 15));
        if (poke_busy) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        waitDone(target, 30);
    endtask

    function automatic logic [NC*32-1:0] fillAll(input int val);
        logic [NC*32-1:0] lg;
        for (int k = 0; k < NC; k++) lg[k*32 +: 32] = 32'(val);
        return lg;
    endfunction

    initial begin
        logic [NC*32-1:0] lg;
        logic [3:0]       lbl;
        int               mode;
        int               base;
        exp_t             e;
        int               pick [4];

        total     = 0;
        bad       = 0;
        cyc       = 0;
        done_seen = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        logits    = '0;
        label     = '0;
        pick      = '{-5, 0, 7, 300};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_grad", grad_out, '0);
        checkOutput("reset_pred", pred_class, '0);
        checkOutput("reset_abs", abs_err, '0);
        checkOutput("reset_flags", {correct, label_err, busy, done}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Nominal: logits k*512, label 9.
        for (int k = 0; k < NC; k++) lg[k*32 +: 32] = 32'(k * 512);
        applyStimulus(lg, 4'd9, 1'b0);
        checkOutput("nom_grad_4", grad_out[4*16 +: 16], 16'd8);
        checkOutput("nom_grad_9", grad_out[9*16 +: 16], 16'd17);
        checkOutput("nom_pred", pred_class, 4'd9);
        checkOutput("nom_correct", correct, 1'b1);
        checkOutput("nom_abs", abs_err, 32'd89);

        // Reset asserted mid-SCAN aborts the pass.
        waitIdle();
        logits = lg;
        label  = 4'd9;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_grad", grad_out, '0);
        checkOutput("abort_abs", abs_err, '0);
        checkOutput("abort_flags", {pred_class, correct, label_err, busy, done}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(lg, 4'd9, 1'b0);
        checkOutput("post_abort_abs", abs_err, 32'd89);

        // Negative logits and floor rounding.
        lg = '0;
        lg[3*32 +: 32] = 32'(-300);
        lg[5*32 +: 32] = 32'(-1);
        applyStimulus(lg, 4'd3, 1'b0);
        checkOutput("neg_grad_3", grad_out[3*16 +: 16], 16'hFFFD);
        checkOutput("neg_grad_5", grad_out[5*16 +: 16], 16'hFFFF);
        checkOutput("neg_grad_0", grad_out[0 +: 16], 16'h0000);
        checkOutput("neg_abs", abs_err, 32'd4);

        // Saturation at both ends.
        lg = '0;
        lg[0 +: 32]  = 32'h7FFF_FFFF;
        lg[32 +: 32] = 32'h8000_0000;
        applyStimulus(lg, 4'd2, 1'b0);
        checkOutput("sat_grad_0", grad_out[0 +: 16], 16'h7FFF);
        checkOutput("sat_grad_1", grad_out[16 +: 16], 16'h8000);
        checkOutput("sat_abs", abs_err, 32'd65536);
        checkOutput("sat_pred", pred_class, 4'd0);

        // Ties and invalid label.
        applyStimulus(fillAll(100), 4'd12, 1'b0);
        checkOutput("tie_pred", pred_class, 4'd0);
        checkOutput("tie_lerr", label_err, 1'b1);
        checkOutput("tie_correct", correct, 1'b0);
        checkOutput("tie_grad", grad_out, '0);

        // Start pulsed while busy must not create a second pass.
        for (int k = 0; k < NC; k++) lg[k*32 +: 32] = 32'((k * 37) % 11 * 100);
        applyStimulus(lg, 4'd4, 1'b1);
        repeat (20) @(negedge clk);

        // Start held high: passes every 14 cycles.
        waitIdle();
        for (int k = 0; k < NC; k++) lg[k*32 +: 32] = 32'(1000 - k * 300);
        logits = lg;
        label  = 4'd0;
        start  = 1'b1;
        base   = done_seen;
        e      = model(lg, 4'd0);
        for (int n = 0; n < 3; n++) begin
            e.done_cyc = cyc + 13 + 14 * n;
            exp_q.push_back(e);
        end
        waitDone(base + 3, 60);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("held_passes", done_seen - base, 3);

        // Randomized passes.
        for (int p = 0; p < 40; p++) begin
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < NC; k++) begin
                case (mode)
                    0:       lg[k*32 +: 32] = 32'(int'($urandom_range(0, 4000)) - 2000);
                    1:       lg[k*32 +: 32] = $urandom();
                    default: lg[k*32 +: 32] = 32'(pick[$urandom_range(0, 3)]);
                endcase
            end
            if ($urandom_range(0, 3) != 0) lbl = 4'($urandom_range(0, 9));
            else lbl = 4'($urandom_range(0, 15));
            applyStimulus(lg, lbl, ($urandom_range(0, 4) == 0));
        end

        repeat (20) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
